// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the 16-bit CPU: sequences FETCH/DECODE/EXEC/MEM/WB and drives every datapath strobe.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcodes halt the core until reset instead of acting as NOP).
module mc_control_fsm #(
  parameter int OP_SIZE = 4,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_SIZE-1:0] opcode,
  input  logic               alu_zero_flag,
  input  logic               mem_ready,
  output logic [OP_SIZE-1:0] alu_sel,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_byte,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               halted,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_EXEC_R   = STATE_W'(2),
    S_R_WB     = STATE_W'(3),
    S_EXEC_I   = STATE_W'(4),
    S_I_WB     = STATE_W'(5),
    S_MEM_ADDR = STATE_W'(6),
    S_MEM_RD   = STATE_W'(7),
    S_MEM_WB   = STATE_W'(8),
    S_MEM_WR   = STATE_W'(9),
    S_BRANCH   = STATE_W'(10),
    S_JUMP     = STATE_W'(11),
    S_ILLEGAL  = STATE_W'(12)
  } state_t;

  localparam logic [OP_SIZE-1:0] OP_NOP  = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] OP_LW   = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] OP_LB   = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] OP_SW   = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_SB   = OP_SIZE'(4);
  localparam logic [OP_SIZE-1:0] OP_AND  = OP_SIZE'(5);
  localparam logic [OP_SIZE-1:0] OP_OR   = OP_SIZE'(6);
  localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(7);
  localparam logic [OP_SIZE-1:0] OP_SUB  = OP_SIZE'(8);
  localparam logic [OP_SIZE-1:0] OP_SLT  = OP_SIZE'(9);
  localparam logic [OP_SIZE-1:0] OP_BEQ  = OP_SIZE'(10);
  localparam logic [OP_SIZE-1:0] OP_JUMP = OP_SIZE'(11);
  localparam logic [OP_SIZE-1:0] OP_ADDI = OP_SIZE'(12);

  state_t             r_state;
  state_t             w_next_state;
  logic [OP_SIZE-1:0] r_alu_sel;
  logic               r_alu_src_a;
  logic [1:0]         r_alu_src_b;
  logic [1:0]         r_pc_src;
  logic               r_mem_read;
  logic               r_mem_write;
  logic               r_mem_byte;
  logic               r_reg_write;
  logic               r_reg_dst;
  logic               r_mem_to_reg;
  logic               r_halted;
  logic               w_fetch_done;

  // Memory handshake: a request (mem_read/mem_write) stays asserted and stable until the
  // cycle mem_ready is high; that cycle completes the access. The first FETCH cycle after
  // reset has no request out yet, so mem_ready is not consumed there.
  assign w_fetch_done = (r_state == S_FETCH) && r_mem_read && mem_ready;

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = w_fetch_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_NOP:                     w_next_state = S_FETCH;
          OP_LW, OP_LB, OP_SW, OP_SB: w_next_state = S_MEM_ADDR;
          OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT:
                                      w_next_state = S_EXEC_R;
          OP_BEQ:                     w_next_state = S_BRANCH;
          OP_JUMP:                    w_next_state = S_JUMP;
          OP_ADDI:                    w_next_state = S_EXEC_I;
          default:                    w_next_state = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:   w_next_state = S_R_WB;
      S_R_WB:     w_next_state = S_FETCH;
      S_EXEC_I:   w_next_state = S_I_WB;
      S_I_WB:     w_next_state = S_FETCH;
      S_MEM_ADDR: w_next_state = (opcode == OP_LW || opcode == OP_LB) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_next_state = S_FETCH;
      S_MEM_WR:   w_next_state = mem_ready ? S_FETCH : S_MEM_WR;
      S_BRANCH:   w_next_state = S_FETCH;
      S_JUMP:     w_next_state = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL:  w_next_state = S_ILLEGAL;
`else
      S_ILLEGAL:  w_next_state = S_FETCH;
`endif
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Outputs are decoded from the state being entered and registered with it, so they
  // are pure functions of the current state as seen from outside.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_alu_sel    <= '0;
      r_alu_src_a  <= 1'b0;
      r_alu_src_b  <= 2'd0;
      r_pc_src     <= 2'd0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_byte   <= 1'b0;
      r_reg_write  <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_alu_sel    <= '0;
      r_alu_src_a  <= 1'b0;
      r_alu_src_b  <= 2'd0;
      r_pc_src     <= 2'd0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_byte   <= 1'b0;
      r_reg_write  <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_halted     <= 1'b0;
      case (w_next_state)
        S_FETCH: begin
          r_mem_read  <= 1'b1;
          r_alu_src_b <= 2'd1;
          r_alu_sel   <= OP_ADD;
        end
        S_DECODE: begin
          r_alu_src_b <= 2'd2;
          r_alu_sel   <= OP_ADD;
        end
        S_EXEC_R: begin
          r_alu_src_a <= 1'b1;
          r_alu_sel   <= opcode;
        end
        S_R_WB: begin
          r_reg_write <= 1'b1;
          r_reg_dst   <= 1'b1;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          r_alu_src_a <= 1'b1;
          r_alu_src_b <= 2'd2;
          r_alu_sel   <= OP_ADD;
        end
        S_I_WB: r_reg_write <= 1'b1;
        S_MEM_RD: begin
          r_mem_read <= 1'b1;
          r_mem_byte <= (opcode == OP_LB);
        end
        S_MEM_WB: begin
          r_reg_write  <= 1'b1;
          r_mem_to_reg <= 1'b1;
        end
        S_MEM_WR: begin
          r_mem_write <= 1'b1;
          r_mem_byte  <= (opcode == OP_SB);
        end
        S_BRANCH: begin
          r_alu_src_a <= 1'b1;
          r_alu_sel   <= OP_SUB;
          r_pc_src    <= 2'd1;
        end
        S_JUMP: r_pc_src <= 2'd2;
`ifdef ILLEGAL_TRAP_EN
        S_ILLEGAL: r_halted <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // PC/IR loads qualify on inputs sampled in their own state (memory data, ALU zero).
  assign ir_write   = w_fetch_done;
  assign pc_write   = w_fetch_done || (r_state == S_JUMP) ||
                      ((r_state == S_BRANCH) && alu_zero_flag);
  assign alu_sel    = r_alu_sel;
  assign alu_src_a  = r_alu_src_a;
  assign alu_src_b  = r_alu_src_b;
  assign pc_src     = r_pc_src;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_byte   = r_mem_byte;
  assign reg_write  = r_reg_write;
  assign reg_dst    = r_reg_dst;
  assign mem_to_reg = r_mem_to_reg;
  assign halted     = r_halted;
  assign state_dbg  = r_state;

endmodule
